// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer in front of a single-port block RAM.
//   Serialises port 0 (CPU data) and port 1 (fetch/loader) accesses, hides the
//   RAM's one-cycle registered read and returns a one-cycle ack per transaction.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_reqN/i_weN/i_addrN/i_wdataN  port N request, held stable until o_ackN
//   o_ackN                         port N one-cycle completion pulse
//   o_rdataN                       port N read data, valid with o_ackN, held afterwards
//   o_ram_wren/o_ram_addr/o_ram_data  RAM write enable, address, write data
//   i_ram_q                        RAM registered read data
module mem_arbiter #(
    parameter int unsigned AW         = 12,
    parameter int unsigned DW         = 16,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req0,
    input  logic          i_we0,
    input  logic [AW-1:0] i_addr0,
    input  logic [DW-1:0] i_wdata0,
    output logic          o_ack0,
    output logic [DW-1:0] o_rdata0,
    input  logic          i_req1,
    input  logic          i_we1,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata1,
    output logic          o_ack1,
    output logic [DW-1:0] o_rdata1,
    output logic          o_ram_wren,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_data,
    input  logic [DW-1:0] i_ram_q
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRd   = 2'd1,
        StAck  = 2'd2
    } state_e;

    state_e        r_state, w_state_d;
    logic          r_win, w_win_d;
    logic [AW-1:0] r_addr, w_addr_d;
    logic          r_rr_last, w_rr_last_d;
    logic          r_ack0, w_ack0_d;
    logic          r_ack1, w_ack1_d;
    logic [DW-1:0] r_rdata0, w_rdata0_d;
    logic [DW-1:0] r_rdata1, w_rdata1_d;

    logic          w_any_req;
    logic          w_gnt;
    logic          w_gnt_we;
    logic [AW-1:0] w_gnt_addr;
    logic [DW-1:0] w_gnt_data;

    // Winner selection; only meaningful in StIdle.
    always_comb begin
        w_any_req = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            // Round-robin grants the port that did not win last time.
            w_gnt = FIXED_PRIO ? 1'b0 : ~r_rr_last;
        end else begin
            w_gnt = i_req1;
        end
        w_gnt_we   = w_gnt ? i_we1    : i_we0;
        w_gnt_addr = w_gnt ? i_addr1  : i_addr0;
        w_gnt_data = w_gnt ? i_wdata1 : i_wdata0;
    end

    always_comb begin
        w_state_d   = r_state;
        w_win_d     = r_win;
        w_addr_d    = r_addr;
        w_rr_last_d = r_rr_last;
        w_ack0_d    = 1'b0;
        w_ack1_d    = 1'b0;
        w_rdata0_d  = r_rdata0;
        w_rdata1_d  = r_rdata1;
        o_ram_wren  = 1'b0;
        o_ram_addr  = r_addr;
        o_ram_data  = w_gnt_data;

        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    // Drive the RAM straight from the winner so a write lands this edge.
                    o_ram_wren  = w_gnt_we;
                    o_ram_addr  = w_gnt_addr;
                    w_win_d     = w_gnt;
                    w_addr_d    = w_gnt_addr;
                    w_rr_last_d = w_gnt;
                    if (w_gnt_we) begin
                        w_state_d = StAck;
                        w_ack0_d  = ~w_gnt;
                        w_ack1_d  = w_gnt;
                    end else begin
                        w_state_d = StRd;
                    end
                end
            end
            StRd: begin
                // RAM output now reflects the address issued in StIdle.
                w_state_d = StAck;
                if (r_win) begin
                    w_ack1_d   = 1'b1;
                    w_rdata1_d = i_ram_q;
                end else begin
                    w_ack0_d   = 1'b1;
                    w_rdata0_d = i_ram_q;
                end
            end
            StAck: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_win     <= 1'b0;
            r_addr    <= '0;
            r_rr_last <= 1'b1;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_state   <= w_state_d;
            r_win     <= w_win_d;
            r_addr    <= w_addr_d;
            r_rr_last <= w_rr_last_d;
            r_ack0    <= w_ack0_d;
            r_ack1    <= w_ack1_d;
            r_rdata0  <= w_rdata0_d;
            r_rdata1  <= w_rdata1_d;
        end
    end

    assign o_ack0   = r_ack0;
    assign o_ack1   = r_ack1;
    assign o_rdata0 = r_rdata0;
    assign o_rdata1 = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: runs a round-robin and a fixed-priority arbiter side by side, each in
// front of its own behavioural RAM, against a transaction-level timing/data model.
module tb_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          t_req0[2], t_we0[2], t_req1[2], t_we1[2];
    logic [AW-1:0] t_addr0[2], t_addr1[2];
    logic [DW-1:0] t_wdata0[2], t_wdata1[2];
    logic          o_ack0[2], o_ack1[2];
    logic [DW-1:0] o_rdata0[2], o_rdata1[2];
    logic          ram_wren[2];
    logic [AW-1:0] ram_addr[2];
    logic [DW-1:0] ram_data[2], ram_q[2];

    // Behavioural RAMs: synchronous write, registered read, contents survive reset.
    logic [DW-1:0] ram_mem[2][4096];
    bit            mem_ready;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int d = 0; d < 2; d++)
                for (int a = 0; a < 4096; a++) ram_mem[d][a] <= '0;
            mem_ready <= 1'b1;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (ram_wren[d]) ram_mem[d][ram_addr[d]] <= ram_data[d];
                ram_q[d] <= ram_mem[d][ram_addr[d]];
            end
        end
    end

    mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b0)) u_dut_rr (
        .clk(clk), .rst_n(rst_n),
        .i_req0(t_req0[0]), .i_we0(t_we0[0]), .i_addr0(t_addr0[0]), .i_wdata0(t_wdata0[0]),
        .o_ack0(o_ack0[0]), .o_rdata0(o_rdata0[0]),
        .i_req1(t_req1[0]), .i_we1(t_we1[0]), .i_addr1(t_addr1[0]), .i_wdata1(t_wdata1[0]),
        .o_ack1(o_ack1[0]), .o_rdata1(o_rdata1[0]),
        .o_ram_wren(ram_wren[0]), .o_ram_addr(ram_addr[0]), .o_ram_data(ram_data[0]),
        .i_ram_q(ram_q[0])
    );

    mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b1)) u_dut_fp (
        .clk(clk), .rst_n(rst_n),
        .i_req0(t_req0[1]), .i_we0(t_we0[1]), .i_addr0(t_addr0[1]), .i_wdata0(t_wdata0[1]),
        .o_ack0(o_ack0[1]), .o_rdata0(o_rdata0[1]),
        .i_req1(t_req1[1]), .i_we1(t_we1[1]), .i_addr1(t_addr1[1]), .i_wdata1(t_wdata1[1]),
        .o_ack1(o_ack1[1]), .o_rdata1(o_rdata1[1]),
        .o_ram_wren(ram_wren[1]), .o_ram_addr(ram_addr[1]), .o_ram_data(ram_data[1]),
        .i_ram_q(ram_q[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: per arbiter, when it is next free, which ack is due and when.
    int            cyc;
    int            free_at[2];
    int            ack_cyc[2];
    bit            ack_port[2];
    bit            ack_rd[2];
    logic [DW-1:0] ack_data[2];
    bit            rr_last[2];
    logic [AW-1:0] last_addr[2];
    logic [DW-1:0] exp_rd0[2], exp_rd1[2];
    logic [DW-1:0] ref_mem[2][4096];

    // Requesters, index k = dut*2 + port.
    bit   active[4];
    txn_t cur[4];
    txn_t txq[4][$];

    task automatic drive(input int d, input int p, input logic req, input txn_t t);
        if (p == 0) begin
            t_req0[d] = req; t_we0[d] = t.we; t_addr0[d] = t.addr; t_wdata0[d] = t.data;
        end else begin
            t_req1[d] = req; t_we1[d] = t.we; t_addr1[d] = t.addr; t_wdata1[d] = t.data;
        end
    endtask

    task automatic push(input int p, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] v);
        txn_t t;
        t.we = we; t.addr = a; t.data = v;
        txq[p].push_back(t);
        txq[2 + p].push_back(t);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            free_at[d] = 0; ack_cyc[d] = -1; ack_port[d] = 0; ack_rd[d] = 0;
            ack_data[d] = '0; rr_last[d] = 1'b1; last_addr[d] = '0;
            exp_rd0[d] = '0; exp_rd1[d] = '0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            bit e0, e1, seen;
            int k;
            e0 = (ack_cyc[d] == cyc) && !ack_port[d];
            e1 = (ack_cyc[d] == cyc) && ack_port[d];
            if (ack_cyc[d] == cyc && ack_rd[d]) begin
                if (ack_port[d]) exp_rd1[d] = ack_data[d];
                else             exp_rd0[d] = ack_data[d];
            end
            check($sformatf("ack0[dut%0d]", d), 32'(o_ack0[d]), 32'(e0));
            check($sformatf("ack1[dut%0d]", d), 32'(o_ack1[d]), 32'(e1));
            check($sformatf("rdata0[dut%0d]", d), 32'(o_rdata0[d]), 32'(exp_rd0[d]));
            check($sformatf("rdata1[dut%0d]", d), 32'(o_rdata1[d]), 32'(exp_rd1[d]));
            for (int p = 0; p < 2; p++) begin
                k = d * 2 + p;
                seen = (p == 0) ? o_ack0[d] : o_ack1[d];
                if (active[k] && seen) begin
                    active[k] = 1'b0;
                    drive(d, p, 1'b0, cur[k]);
                end
                if (!active[k] && txq[k].size() > 0) begin
                    cur[k] = txq[k].pop_front();
                    active[k] = 1'b1;
                    drive(d, p, 1'b1, cur[k]);
                end
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            bit r0, r1, g;
            txn_t t;
            r0 = active[d * 2];
            r1 = active[d * 2 + 1];
            if (cyc >= free_at[d] && (r0 || r1)) begin
                if (r0 && r1) g = (d == 1) ? 1'b0 : !rr_last[d];
                else          g = r1;
                rr_last[d] = g;
                t = cur[d * 2 + int'(g)];
                last_addr[d] = t.addr;
                ack_port[d] = g;
                check($sformatf("wren_grant[dut%0d]", d), 32'(ram_wren[d]), 32'(t.we));
                check($sformatf("addr_grant[dut%0d]", d), 32'(ram_addr[d]), 32'(t.addr));
                if (t.we) begin
                    check($sformatf("wdata[dut%0d]", d), 32'(ram_data[d]), 32'(t.data));
                    ref_mem[d][t.addr] = t.data;
                    ack_rd[d] = 1'b0;
                    ack_cyc[d] = cyc + 1;
                    free_at[d] = cyc + 2;
                end else begin
                    ack_data[d] = ref_mem[d][t.addr];
                    ack_rd[d] = 1'b1;
                    ack_cyc[d] = cyc + 2;
                    free_at[d] = cyc + 3;
                end
            end else begin
                check($sformatf("wren_idle[dut%0d]", d), 32'(ram_wren[d]), 32'h0);
                check($sformatf("addr_hold[dut%0d]", d), 32'(ram_addr[d]), 32'(last_addr[d]));
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        txn_t z;
        z = '0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            active[k] = 1'b0;
            txq[k].delete();
            drive(k / 2, k % 2, 1'b0, z);
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ack0[dut%0d]", d), 32'(o_ack0[d]), 32'h0);
            check($sformatf("rst_ack1[dut%0d]", d), 32'(o_ack1[d]), 32'h0);
            check($sformatf("rst_rdata0[dut%0d]", d), 32'(o_rdata0[d]), 32'h0);
            check($sformatf("rst_rdata1[dut%0d]", d), 32'(o_rdata1[d]), 32'h0);
            check($sformatf("rst_wren[dut%0d]", d), 32'(ram_wren[d]), 32'h0);
            check($sformatf("rst_addr[dut%0d]", d), 32'(ram_addr[d]), 32'h0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cyc += 3;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        txn_t z;
        z = '0;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            active[k] = 1'b0;
            drive(k / 2, k % 2, 1'b0, z);
        end
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 4096; a++) ref_mem[d][a] = '0;
        cyc = 0;
        model_reset();
        do_reset();

        // Single write, then a read of it from the other port.
        push(0, 1'b1, 12'h005, 16'hBEEF);
        run(4);
        push(1, 1'b0, 12'h005, 16'h0000);
        run(5);

        // Top address is usable and does not alias address 0.
        push(0, 1'b1, 12'hFFF, 16'h1234);
        run(3);
        push(0, 1'b0, 12'hFFF, 16'h0000);
        push(1, 1'b0, 12'h000, 16'h0000);
        run(8);

        // Both ports reading back-to-back: alternation vs fixed priority.
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 12'h005, 16'h0000);
            push(1, 1'b0, 12'hFFF, 16'h0000);
        end
        run(30);

        // Reset while a port 0 read sits in the RAM read cycle.
        push(0, 1'b0, 12'h005, 16'h0000);
        step();
        do_reset();
        run(3);
        push(0, 1'b0, 12'h005, 16'h0000);
        run(5);

        // Randomised traffic on both ports.
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (txq[k].size() == 0 && $urandom_range(0, 2) == 0) begin
                    txn_t t;
                    int   sel;
                    sel = $urandom_range(0, 3);
                    t.we = 1'($urandom_range(0, 1));
                    case (sel)
                        0:       t.addr = 12'h000;
                        1:       t.addr = 12'hFFF;
                        2:       t.addr = 12'($urandom_range(0, 7));
                        default: t.addr = 12'($urandom);
                    endcase
                    t.data = 16'($urandom);
                    txq[k].push_back(t);
                end
            end
            step();
        end
        run(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
